// File: rtl/ascon_pack.sv
// ascon_pack: shared ASCON types and constants.
//   type_word    : one 64-bit lane of the state.
//   type_state   : full 320-bit state; element k is lane xk.
//   type_ser_fsm : state encoding of the state_serializer FSM.
// Constants:
//   NB_WORDS_C      : number of lanes in type_state.
//   WORD_W_C        : width of one lane.
//   TAG_START_IDX_C : first lane streamed when only the tag (x3, x4) is sent.
package ascon_pack;
  localparam int NB_WORDS_C = 5;
  localparam int WORD_W_C   = 64;
  localparam logic [2:0] TAG_START_IDX_C = 3'd3;

  typedef logic [WORD_W_C-1:0] type_word;
  typedef type_word [NB_WORDS_C-1:0] type_state;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } type_ser_fsm;
endpackage

// File: rtl/state_serializer_word_counter.sv
// word_counter: 3-bit lane index counter for state_serializer.
// Ports:
//   clock_i     : system clock, rising edge.
//   reset_i     : synchronous active-high reset, count returns to 0.
//   start_i     : load start_val_i into the counter (has priority over inc_i).
//   start_val_i : first index of a new stream.
//   inc_i       : advance by one; ignored once the last index is reached.
//   count_o     : current index.
//   is_last_o   : count_o equals LAST_IDX.
module word_counter #(
  parameter int LAST_IDX = 4
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [2:0] start_val_i,
  input  logic       inc_i,
  output logic [2:0] count_o,
  output logic       is_last_o
);
  logic [2:0] count_q;
  logic [2:0] count_d;
  logic       is_last;

  assign is_last = (count_q == 3'(LAST_IDX));

  always_comb begin
    count_d = count_q;
    if (start_i) begin
      count_d = start_val_i;
    end else if (inc_i && !is_last) begin
      // Saturate at the last index so the counter never walks past x4.
      count_d = count_q + 3'd1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count_q <= 3'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign is_last_o = is_last;
endmodule

// File: rtl/state_serializer.sv
// state_serializer: reader end of the ASCON 320-bit state register.
// Captures a type_state snapshot on load_i and streams it out as 64-bit
// words x0..x4 over a valid/ready handshake.
// Optional build macro: SER_TAG_MODE_EN adds tag_mode_i; when set with an
// accepted load only x3 and x4 are streamed.
// Ports:
//   clock_i    : system clock, rising edge.
//   reset_i    : synchronous active-high reset; abandons a stream, no done_o.
//   tag_mode_i : (SER_TAG_MODE_EN only) sampled with an accepted load.
//   load_i     : capture strobe for data_i.
//   data_i     : state snapshot, element k = xk.
//   busy_o     : FSM is in SEND (also serves as the FSM state observation).
//   valid_o    : word_o holds a valid word.
//   ready_i    : downstream accepts word_o this cycle.
//   word_o     : current output word.
//   idx_o      : index of word_o.
//   last_o     : word_o is the final word of the snapshot.
//   done_o     : one-cycle pulse after the final word transfers.
// Handshake: a word transfers on a rising edge where valid_o && ready_i.
// Once valid_o rises, word_o/idx_o/last_o stay stable and valid_o stays high
// until that transfer happens (no retraction).
module state_serializer
  import ascon_pack::*;
#(
  parameter int NB_WORDS = NB_WORDS_C,
  parameter int WORD_W   = WORD_W_C
) (
  input  logic              clock_i,
  input  logic              reset_i,
`ifdef SER_TAG_MODE_EN
  input  logic              tag_mode_i,
`endif
  input  logic              load_i,
  input  type_state         data_i,
  output logic              busy_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [WORD_W-1:0] word_o,
  output logic [2:0]        idx_o,
  output logic              last_o,
  output logic              done_o
);
  type_ser_fsm state_q, state_d;
  type_state   shadow_q, shadow_d;
  logic        done_q, done_d;

  logic [2:0]  idx;
  logic        idx_is_last;
  logic        xfer;
  logic        final_xfer;
  logic        load_acc;
  logic [2:0]  start_idx;
  logic [WORD_W-1:0] word_sel;

  assign xfer       = (state_q == SEND) && ready_i;
  assign final_xfer = xfer && idx_is_last;
  // A new snapshot may only replace the shadow once the old one is fully out.
  assign load_acc   = load_i && ((state_q == IDLE) || final_xfer);

`ifdef SER_TAG_MODE_EN
  assign start_idx = tag_mode_i ? TAG_START_IDX_C : 3'd0;
`else
  assign start_idx = 3'd0;
`endif

  word_counter #(
    .LAST_IDX (NB_WORDS - 1)
  ) u_word_counter (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .start_i     (load_acc),
    .start_val_i (start_idx),
    .inc_i       (xfer),
    .count_o     (idx),
    .is_last_o   (idx_is_last)
  );

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    done_d   = final_xfer;
    if (load_acc) begin
      // Covers the back-to-back case: a load on the final transfer keeps SEND.
      state_d  = SEND;
      shadow_d = data_i;
    end else if (final_xfer) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    word_sel = '0;
    for (int k = 0; k < NB_WORDS; k++) begin
      if (idx == 3'(k)) begin
        word_sel = shadow_q[k];
      end
    end
  end

  assign busy_o  = (state_q == SEND);
  assign valid_o = (state_q == SEND);
  assign word_o  = word_sel;
  assign idx_o   = idx;
  assign last_o  = (state_q == SEND) && idx_is_last;
  assign done_o  = done_q;
endmodule

// File: tb/tb_state_serializer.sv
module tb_state_serializer;
  import ascon_pack::*;

  // ---------------- clock / reset ----------------
  logic        clock_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        load_i  = 1'b0;
  logic        ready_i = 1'b0;
  type_state   data_i  = '0;
`ifdef SER_TAG_MODE_EN
  logic        tag_mode_i = 1'b0;
`endif
  logic        busy_o, valid_o, last_o, done_o;
  logic [63:0] word_o;
  logic [2:0]  idx_o;

  always #5 clock_i = ~clock_i;

  state_serializer dut (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
`ifdef SER_TAG_MODE_EN
    .tag_mode_i (tag_mode_i),
`endif
    .load_i     (load_i),
    .data_i     (data_i),
    .busy_o     (busy_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .word_o     (word_o),
    .idx_o      (idx_o),
    .last_o     (last_o),
    .done_o     (done_o)
  );

  // ---------------- scoreboard ----------------
  localparam int W = 68;  // {last, idx[2:0], word[63:0]}
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  logic done_pending = 1'b0;
  logic hold_prev    = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] ent(input logic last, input logic [2:0] idx, input logic [63:0] w);
    return {last, idx, w};
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clock_i) begin
    logic [W-1:0] got;
    logic [W-1:0] head;
    got = {last_o, idx_o, word_o};
    if (done_o || done_pending) check("done_pulse", W'(done_o), W'(done_pending));
    done_pending = 1'b0;
    if (reset_i) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) check("valid_hold", W'(valid_o), W'(1));
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", got, '0);
        end else begin
          head = exp_q[0];
          check("word", got, head);
          if (ready_i) begin
            void'(exp_q.pop_front());
            done_pending = head[W-1];
          end
        end
      end
      hold_prev = valid_o && !ready_i;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  function automatic type_state make_state(input logic [55:0] pat);
    type_state s;
    for (int k = 0; k < NB_WORDS_C; k++) s[k] = {pat, 8'(k + 1)};
    return s;
  endfunction

  // Queue the words a snapshot is expected to produce.
  task automatic push_stream(input type_state s, input int first);
    for (int k = first; k < NB_WORDS_C; k++)
      exp_q.push_back(ent(k == 4, 3'(k), s[k]));
  endtask

  // Present load_i for one edge (caller decides whether it is accepted).
  task automatic drive_load(input type_state s, input logic tag);
    load_i = 1'b1;
    data_i = s;
`ifdef SER_TAG_MODE_EN
    tag_mode_i = tag;
`else
    if (tag) $display("note: tag load requested without tag mode build");
`endif
    tick();
    load_i = 1'b0;
`ifdef SER_TAG_MODE_EN
    tag_mode_i = 1'b0;
`endif
  endtask

  task automatic wait_idle(input string name);
    bit seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock_i);
      if (!busy_o) begin
        seen = 1;
        break;
      end
    end
    check({name, "_idle_timeout"}, W'(seen), W'(1));
    tick();
    tick();
    check({name, "_queue_empty"}, W'(exp_q.size()), W'(0));
  endtask

  task automatic check_quiet(input string name);
    @(negedge clock_i);
    check({name, "_valid"}, W'(valid_o), W'(0));
    check({name, "_busy"},  W'(busy_o),  W'(0));
    check({name, "_done"},  W'(done_o),  W'(0));
    check({name, "_last"},  W'(last_o),  W'(0));
  endtask

  // ---------------- stimulus ----------------
  type_state s1, s_aa, s_bb, s2;

  initial begin
    s1 = '0;
    for (int k = 0; k < NB_WORDS_C; k++) s1[k] = 64'(k + 1);
    s_aa = make_state(56'hAAAA_AAAA_AAAA_AA);
    s_bb = make_state(56'hBBBB_BBBB_BBBB_BB);
    s2   = make_state(56'h0123_4567_89AB_CD);

    // Reset then idle.
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    check_quiet("reset");
    check("reset_word", W'(word_o), W'(0));
    check("reset_idx",  W'(idx_o),  W'(0));
    tick();

    // Full stream with ready held high; latency of one cycle.
    ready_i = 1'b1;
    push_stream(s1, 0);
    drive_load(s1, 1'b0);
    @(negedge clock_i);
    check("load_latency_valid", W'(valid_o), W'(1));
    check("load_latency_busy",  W'(busy_o),  W'(1));
    wait_idle("full");

    // Backpressure at idx 2 for three cycles.
    push_stream(s1, 0);
    drive_load(s1, 1'b0);  // E0
    tick();                // E1: x0 out
    tick();                // E2: x1 out, idx now 2
    ready_i = 1'b0;
    tick();
    tick();
    tick();
    @(negedge clock_i);
    check("bp_idx",  W'(idx_o),  W'(2));
    check("bp_word", W'(word_o), W'(64'h3));
    @(posedge clock_i);
    #1;
    ready_i = 1'b1;
    wait_idle("backpressure");

    // Ignored mid-stream load, then back-to-back load on the final transfer.
    push_stream(s1, 0);
    push_stream(s_bb, 0);
    drive_load(s1, 1'b0);  // E0
    tick();                // E1
    drive_load(s_aa, 1'b0);// E2: ignored
    tick();                // E3
    tick();                // E4: idx 4 showing
    drive_load(s_bb, 1'b0);// E5: final transfer + accepted load
    @(negedge clock_i);
    check("b2b_done",  W'(done_o),  W'(1));
    check("b2b_valid", W'(valid_o), W'(1));
    check("b2b_idx",   W'(idx_o),   W'(0));
    check("b2b_word",  W'(word_o),  W'(s_bb[0]));
    wait_idle("b2b");

    // Reset mid-stream at idx 2, then a fresh load.
    push_stream(s1, 0);
    drive_load(s1, 1'b0);  // E0
    tick();                // E1
    tick();                // E2: idx 2
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    exp_q.delete();
    check_quiet("mid_reset");
    tick();
    check_quiet("mid_reset_nodone");
    tick();
    push_stream(s2, 0);
    drive_load(s2, 1'b0);
    @(negedge clock_i);
    check("restart_idx", W'(idx_o), W'(0));
    wait_idle("restart");

`ifdef SER_TAG_MODE_EN
    // Tag mode: only x3 and x4.
    push_stream(s2, 3);
    drive_load(s2, 1'b1);
    @(negedge clock_i);
    check("tag_first_idx", W'(idx_o), W'(3));
    wait_idle("tag");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #50000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "time limit");
  end
endmodule
